theta_column_apply: RTL and testbench

//  Inverse/companion of the 5-byte column-parity XOR reduction: takes the 800-bit state and its
//  160-bit column parity (20 bytes) and folds the parity back into every byte of each column.

---
 rtl/aes_sha_pkg.sv | 24 ++
 rtl/theta_col_xor.sv | 12 +
 rtl/theta_column_apply.sv | 126 ++++++++++++
 tb/tb_theta_column_apply.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_sha_pkg.sv
// rtl/aes_sha_pkg.sv - shared widths, types and byte helpers for the theta column stages
package aes_sha_pkg;

    localparam int NUM_COLS      = 20;
    localparam int BYTES_PER_COL = 5;
    localparam int COL_W         = 40;
    localparam int STATE_W       = 800;
    localparam int PAR_W         = 160;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [7:0]       byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } theta_state_t;

    // rotate an 8-bit lane left by one position
    function automatic byte_t rotl8(input byte_t x);
        return {x[6:0], x[7]};
    endfunction

endpackage

// File: rtl/theta_col_xor.sv
// rtl/theta_col_xor.sv - folds one D byte into all five bytes of a 40-bit column
module theta_col_xor
    import aes_sha_pkg::*;
(
    input  col_t  col,
    input  byte_t d,
    output col_t  res
);

    assign res = col ^ {BYTES_PER_COL{d}};

endmodule

// File: rtl/theta_column_apply.sv
// rtl/theta_column_apply.sv - column-serial theta parity fold-back; optional THETA_PARITY_CHECK_EN input parity checker
module theta_column_apply
    import aes_sha_pkg::*;
#(
    parameter int COLS_PER_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [PAR_W-1:0]   in_parity,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               par_err
);

    localparam logic [4:0] STEP     = 5'(COLS_PER_CYC);
    localparam logic [4:0] LAST_IDX = 5'(NUM_COLS - COLS_PER_CYC);

    theta_state_t state, state_nxt;
    logic [STATE_W-1:0]           state_q;
    logic [PAR_W-1:0]             par_q;
    logic [4:0]                   col_idx;
    logic [NUM_COLS-1:0][7:0]     d_all;
    logic                         accept;
    logic                         last_step;

    logic [4:0] lane_idx [COLS_PER_CYC];
    col_t       lane_col [COLS_PER_CYC];
    col_t       lane_res [COLS_PER_CYC];

    assign accept    = in_valid && in_ready;
    assign last_step = (col_idx == LAST_IDX);

    // D byte per column from the latched parity: left neighbour xor rotated right neighbour
    always_comb begin
        d_all = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            d_all[i] = par_q[PAR_W-1-8*((i+NUM_COLS-1)%NUM_COLS) -: 8]
                     ^ rotl8(par_q[PAR_W-1-8*((i+1)%NUM_COLS) -: 8]);
        end
    end

    // one xor lane per column handled this cycle, selected by col_idx
    for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_lane
        assign lane_idx[g] = col_idx + 5'(g);
        assign lane_col[g] = state_q[(NUM_COLS-1-int'(lane_idx[g]))*COL_W +: COL_W];
        theta_col_xor u_col (
            .col (lane_col[g]),
            .d   (d_all[lane_idx[g]]),
            .res (lane_res[g])
        );
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) state_nxt = RUN;
            end
            RUN: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand capture, column walk and result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            par_q     <= '0;
            col_idx   <= '0;
            out_state <= '0;
        end else if (accept) begin
            state_q <= in_state;
            par_q   <= in_parity;
            col_idx <= '0;
        end else if (state == RUN) begin
            for (int g = 0; g < COLS_PER_CYC; g++) begin
                out_state[(NUM_COLS-1-int'(lane_idx[g]))*COL_W +: COL_W] <= lane_res[g];
            end
            if (!last_step) col_idx <= col_idx + STEP;
        end
    end

`ifdef THETA_PARITY_CHECK_EN
    logic [PAR_W-1:0] calc_par;

    // parity recomputed from the incoming state, one byte per column
    always_comb begin
        calc_par = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            for (int b = 0; b < BYTES_PER_COL; b++) begin
                calc_par[PAR_W-1-8*i -: 8] = calc_par[PAR_W-1-8*i -: 8]
                                           ^ in_state[STATE_W-1-COL_W*i-8*b -: 8];
            end
        end
    end

    // mismatch flag refreshed on every accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      par_err <= 1'b0;
        else if (accept) par_err <= (calc_par != in_parity);
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_theta_column_apply.sv
// tb/tb_theta_column_apply.sv - directed self-checking bench for theta_column_apply
module tb_theta_column_apply;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, par_err;
    logic [799:0] in_state, out_state;
    logic [159:0] in_parity;

    logic         v_a, or_a;
    logic         r1, r20, ov1, ov20, pe1, pe20;
    logic [799:0] os1, os20;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    theta_column_apply #(.COLS_PER_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_parity(in_parity), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .par_err(par_err));

    theta_column_apply #(.COLS_PER_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_a), .in_ready(r1),
        .in_state(in_state), .in_parity(in_parity), .out_valid(ov1),
        .out_ready(or_a), .out_state(os1), .par_err(pe1));

    theta_column_apply #(.COLS_PER_CYC(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_a), .in_ready(r20),
        .in_state(in_state), .in_parity(in_parity), .out_valid(ov20),
        .out_ready(or_a), .out_state(os20), .par_err(pe20));

    task automatic chk(input string tag, input logic [799:0] got, input logic [799:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [799:0] ref_theta(input logic [799:0] s, input logic [159:0] p);
        logic [7:0]   pb [20];
        logic [7:0]   d, r;
        logic [799:0] o;
        for (int i = 0; i < 20; i++) pb[i] = p[159-8*i -: 8];
        for (int i = 0; i < 20; i++) begin
            r = pb[(i+1)%20];
            d = pb[(i+19)%20] ^ {r[6:0], r[7]};
            for (int b = 0; b < 5; b++) o[799-40*i-8*b -: 8] = s[799-40*i-8*b -: 8] ^ d;
        end
        return o;
    endfunction

    function automatic logic [159:0] par_of(input logic [799:0] s);
        logic [159:0] p = '0;
        for (int i = 0; i < 20; i++)
            for (int b = 0; b < 5; b++) p[159-8*i -: 8] ^= s[799-40*i-8*b -: 8];
        return p;
    endfunction

    function automatic logic exp_perr(input logic [799:0] s, input logic [159:0] p);
`ifdef THETA_PARITY_CHECK_EN
        return par_of(s) != p;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [799:0] rnd800();
        logic [799:0] r;
        for (int i = 0; i < 25; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [159:0] rnd160();
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // drive one transaction into the main DUT and count clocks until out_valid
    task automatic send(input logic [799:0] s, input logic [159:0] p, input logic early, output int lat);
        chk("rdy_pre", in_ready, 1'b1);
        in_state = s; in_parity = p; in_valid = 1'b1; out_ready = early;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("ov_drop", out_valid, 1'b0);
        chk("rdy_back", in_ready, 1'b1);
    endtask

    task automatic full_txn(input string tag, input logic [799:0] s, input logic [159:0] p, input logic [799:0] exp);
        int lat;
        send(s, p, 1'b0, lat);
        chk({tag, "_lat"}, lat, 6);
        chk({tag, "_res"}, out_state, exp);
        chk({tag, "_perr"}, par_err, exp_perr(s, p));
        handshake();
        chk({tag, "_hold"}, out_state, exp);
    endtask

    initial begin
        logic [799:0] s, e2;
        logic [159:0] p;
        int lat, lat1, lat20;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; v_a = 1'b0; or_a = 1'b0;
        in_state = '0; in_parity = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_os", out_state, '0);
        chk("rst_perr", par_err, 1'b0);
        chk("rst_rdy20", r20, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rdy", in_ready, 1'b1);

        // 1: all zero
        full_txn("t1", '0, '0, '0);

        // 2: single parity bit, out_ready asserted early
        p = '0; p[159-8*1 -: 8] = 8'h80;
        e2 = '0;
        e2[799:760] = 40'h0101010101;
        e2[719:680] = 40'h8080808080;
        send('0, p, 1'b1, lat);
        chk("t2_lat", lat, 6);
        chk("t2_res", out_state, e2);
        chk("t2_perr", par_err, exp_perr('0, p));
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("t2_ov_drop", out_valid, 1'b0);
        chk("t2_rdy", in_ready, 1'b1);

        // 3: stall at DONE with in_valid pushing new data
        s = rnd800(); p = rnd160();
        send(s, p, 1'b0, lat);
        chk("t3_lat", lat, 6);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_state = ~s;
            @(posedge clk); @(negedge clk);
            chk("t3_ov", out_valid, 1'b1);
            chk("t3_rdy", in_ready, 1'b0);
            chk("t3_res", out_state, ref_theta(s, p));
        end
        in_valid = 1'b0;
        handshake();
        chk("t3_hold", out_state, ref_theta(s, p));

        // 4: reset mid-run, then a clean transaction
        s = rnd800(); p = rnd160();
        in_state = s; in_parity = p; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_ov", out_valid, 1'b0);
        chk("t4_os", out_state, '0);
        chk("t4_rdy", in_ready, 1'b0);
        chk("t4_perr", par_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s = rnd800(); p = rnd160();
        full_txn("t4b", s, p, ref_theta(s, p));

        // 5: one and twenty columns per clock
        s = rnd800(); p = rnd160();
        in_state = s; in_parity = p; v_a = 1'b1;
        @(posedge clk); @(negedge clk);
        v_a = 1'b0;
        lat1 = 0; lat20 = 0;
        for (int c = 1; c < 40; c++) begin
            if (ov1 && lat1 == 0) lat1 = c;
            if (ov20 && lat20 == 0) lat20 = c;
            if (lat1 != 0 && lat20 != 0) break;
            @(posedge clk); @(negedge clk);
        end
        chk("t5_lat1", lat1, 21);
        chk("t5_lat20", lat20, 2);
        chk("t5_res1", os1, ref_theta(s, p));
        chk("t5_res20", os20, ref_theta(s, p));
        or_a = 1'b1;
        @(posedge clk); @(negedge clk);
        or_a = 1'b0;
        chk("t5_ov1", ov1, 1'b0);
        chk("t5_rdy20", r20, 1'b1);

        // 6: consistent parity, then a single flipped parity bit
        s = rnd800(); p = par_of(s);
        full_txn("t6a", s, p, ref_theta(s, p));
        p[0] = ~p[0];
        full_txn("t6b", s, p, ref_theta(s, p));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
